// File: rtl/sr_latch_sequencer_if.sv
// rtl/sr_latch_sequencer_if.sv - request/latch bus between a controller and the SR latch sequencer
//
// Optional feature macro: SR_SEQ_TOGGLE_EN (adds toggle_req).
//
// Signals:
//   set_req, clr_req   raw asynchronous set / clear request levels
//   toggle_req         raw asynchronous toggle request level (SR_SEQ_TOGGLE_EN only)
//   q_fb, qn_fb        latch Q / Qn feedback, asynchronous to clk
//   S, R, EN           latch set, reset and enable drives
//   busy, done, err    sequencer status
//
// Modports:
//   master  request source and latch side (drives requests and feedback)
//   slave   the sequencer (drives latch inputs and status)

interface sr_latch_sequencer_if;
   logic set_req;
   logic clr_req;
`ifdef SR_SEQ_TOGGLE_EN
   logic toggle_req;
`endif
   logic q_fb;
   logic qn_fb;
   logic S;
   logic R;
   logic EN;
   logic busy;
   logic done;
   logic err;

   modport master (
`ifdef SR_SEQ_TOGGLE_EN
      output toggle_req,
`endif
      output set_req, clr_req, q_fb, qn_fb,
      input  S, R, EN, busy, done, err
   );

   modport slave (
`ifdef SR_SEQ_TOGGLE_EN
      input  toggle_req,
`endif
      input  set_req, clr_req, q_fb, qn_fb,
      output S, R, EN, busy, done, err
   );
endinterface

// File: rtl/sr_latch_sequencer.sv
// rtl/sr_latch_sequencer.sv - clocked S/R/EN sequencer for an enabled SR latch stage
//
// Synchronises and debounces raw set/clear requests, arbitrates them (clear
// first), then walks SETUP -> PULSE -> RELEASE -> CHECK so S=R=1 is never
// presented and S/R are stable around the EN pulse. Latch Q/Qn feedback is
// synchronised and compared in CHECK; a timeout raises a sticky err.
//
// Optional feature macro: SR_SEQ_TOGGLE_EN (toggle_req input, priority
// clear > set > toggle, toggle resolves from synchronised Q).
//
// Parameters:
//   DB_CYCLES     stable synchronised samples before a debounced level flips
//   PULSE_CYCLES  EN high time per operation
//   CHK_CYCLES    cycles allowed in CHECK for feedback to match
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   sr_latch_sequencer_if.slave: requests and feedback in,
//         S/R/EN, busy, done, err out (all outputs registered)

module sr_latch_sequencer #(
   parameter int DB_CYCLES    = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int CHK_CYCLES   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   sr_latch_sequencer_if.slave     bus
);

`ifdef SR_SEQ_TOGGLE_EN
   localparam int NCH = 3;
`else
   localparam int NCH = 2;
`endif
   localparam int CH_CLR = 0;
   localparam int CH_SET = 1;
`ifdef SR_SEQ_TOGGLE_EN
   localparam int CH_TGL = 2;
`endif

   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam int PL_W = $clog2(PULSE_CYCLES + 1);
   localparam int CK_W = $clog2(CHK_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_CYCLES - 1);
   localparam logic [CK_W-1:0] CK_LAST = CK_W'(CHK_CYCLES - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_PULSE   = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_CHECK   = 3'd4;

   localparam logic OP_CLR = 1'b0;
   localparam logic OP_SET = 1'b1;

   logic [NCH-1:0]  req_raw;
   logic [NCH-1:0]  req_s0, req_s1;
   logic [NCH-1:0]  req_db, req_db_d;
   logic [NCH-1:0]  armed;
   logic [NCH-1:0]  pend;
   logic [NCH-1:0]  rise;
   logic [NCH-1:0]  take;
   logic [DB_W-1:0] db_cnt [NCH];
   logic [1:0]      fill;
   logic [1:0]      fb_s0, fb_s1;     // {q, qn}

   logic [2:0]      state, state_nxt;
   logic            op, op_nxt;
   logic [PL_W-1:0] pulse_cnt;
   logic [CK_W-1:0] chk_cnt;
   logic            leave_chk;
   logic            chk_timeout;
   logic            drive;

   assign req_raw[CH_CLR] = bus.clr_req;
   assign req_raw[CH_SET] = bus.set_req;
`ifdef SR_SEQ_TOGGLE_EN
   assign req_raw[CH_TGL] = bus.toggle_req;
`endif

   // Two-flop synchronisers; fill tracks when req_s1 first holds a post-reset sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_s0 <= '0;
         req_s1 <= '0;
         fb_s0  <= '0;
         fb_s1  <= '0;
         fill   <= '0;
      end else begin
         req_s0 <= req_raw;
         req_s1 <= req_s0;
         fb_s0  <= {bus.q_fb, bus.qn_fb};
         fb_s1  <= fb_s0;
         if (fill != 2'd2)
            fill <= fill + 2'd1;
      end
   end

   // Debounce: flip after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_db <= '0;
         for (int i = 0; i < NCH; i++)
            db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (req_s1[i] == req_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               req_db[i] <= req_s1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A channel only reports rising edges after a genuine low level has been
   // seen, so a request already held high across reset is not an edge.
   assign rise = req_db & ~req_db_d & armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_db_d <= '0;
         armed    <= '0;
         pend     <= '0;
      end else begin
         req_db_d <= req_db;
         armed    <= armed | ({NCH{fill == 2'd2}} & ~req_db & ~req_s1);
         // Set wins over take so an edge arriving as its flag is consumed is kept.
         pend     <= (pend & ~take) | rise;
      end
   end

   always_comb begin
      state_nxt   = state;
      op_nxt      = op;
      take        = '0;
      leave_chk   = 1'b0;
      chk_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend[CH_CLR]) begin
               take[CH_CLR] = 1'b1;
               op_nxt       = OP_CLR;
               state_nxt    = ST_SETUP;
            end else if (pend[CH_SET]) begin
               take[CH_SET] = 1'b1;
               op_nxt       = OP_SET;
               state_nxt    = ST_SETUP;
`ifdef SR_SEQ_TOGGLE_EN
            end else if (pend[CH_TGL]) begin
               take[CH_TGL] = 1'b1;
               op_nxt       = fb_s1[1] ? OP_CLR : OP_SET;
               state_nxt    = ST_SETUP;
`endif
            end
         end
         ST_SETUP:   state_nxt = ST_PULSE;
         ST_PULSE:   if (pulse_cnt == PL_LAST) state_nxt = ST_RELEASE;
         ST_RELEASE: state_nxt = ST_CHECK;
         ST_CHECK: begin
            if (fb_s1 == ((op == OP_SET) ? 2'b10 : 2'b01)) begin
               leave_chk = 1'b1;
               state_nxt = ST_IDLE;
            end else if (chk_cnt == CK_LAST) begin
               leave_chk   = 1'b1;
               chk_timeout = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state.
   assign drive = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE) ||
                  (state_nxt == ST_RELEASE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op        <= OP_CLR;
         pulse_cnt <= '0;
         chk_cnt   <= '0;
         bus.S     <= 1'b0;
         bus.R     <= 1'b0;
         bus.EN    <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         op        <= op_nxt;
         pulse_cnt <= (state == ST_PULSE && state_nxt == ST_PULSE) ? pulse_cnt + 1'b1 : '0;
         chk_cnt   <= (state == ST_CHECK && state_nxt == ST_CHECK) ? chk_cnt + 1'b1 : '0;
         bus.S     <= drive && (op_nxt == OP_SET);
         bus.R     <= drive && (op_nxt == OP_CLR);
         bus.EN    <= (state_nxt == ST_PULSE);
         bus.busy  <= (state_nxt != ST_IDLE);
         bus.done  <= leave_chk;
         bus.err   <= bus.err | chk_timeout;
      end
   end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// tb/tb_sr_latch_sequencer.sv - directed self-checking bench for sr_latch_sequencer

module tb_sr_latch_sequencer;
   logic clk = 1'b0;
   logic rst;
   logic q_model  = 1'b0;
   logic fb_force = 1'b0;
   logic mon_on   = 1'b0;
   logic prev_en  = 1'b0;
   logic prev_s   = 1'b0;
   logic prev_r   = 1'b0;
   int   n_cmp    = 0;
   int   n_mis    = 0;
   int   done_cnt = 0;
   int   k;
   int   d0;

   always #5 clk = ~clk;

   sr_latch_sequencer_if bus();

   sr_latch_sequencer #(
      .DB_CYCLES(4),
      .PULSE_CYCLES(2),
      .CHK_CYCLES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Enabled SR latch model with an optional stuck feedback override.
   always @(bus.EN or bus.S or bus.R) begin
      if (bus.EN && bus.S)
         q_model = 1'b1;
      else if (bus.EN && bus.R)
         q_model = 1'b0;
   end
   assign bus.q_fb  = fb_force ? 1'b0 : q_model;
   assign bus.qn_fb = fb_force ? 1'b1 : ~q_model;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.done)
         done_cnt++;
      if (mon_on) begin
         check_eq("s_and_r", 32'(bus.S & bus.R), 32'h0);
         check_eq("en_onehot", 32'(bus.EN ? (bus.S ^ bus.R) : 1'b1), 32'h1);
         if (bus.EN || prev_en)
            check_eq("sr_stable", 32'({bus.S, bus.R}), 32'({prev_s, prev_r}));
      end
      prev_en = bus.EN;
      prev_s  = bus.S;
      prev_r  = bus.R;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!bus.busy && cycles < 40);
      check_eq(tag, 32'(bus.busy), 32'h1);
   endtask

   task automatic wait_done(input string tag);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.done && c < 40);
      check_eq(tag, 32'(bus.done), 32'h1);
   endtask

   task automatic expect_idle(input int n, input string tag);
      logic acc;
      acc = 1'b0;
      repeat (n) begin
         @(negedge clk);
         acc = acc | bus.busy | bus.done;
      end
      check_eq(tag, 32'(acc), 32'h0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.set_req = 1'b1;
      bus.clr_req = 1'b0;
`ifdef SR_SEQ_TOGGLE_EN
      bus.toggle_req = 1'b0;
`endif
      // Reset with set_req already high: outputs clear, no operation follows.
      tick(2);
      check_eq("reset_out", 32'({bus.S, bus.R, bus.EN, bus.busy, bus.done, bus.err}), 32'h0);
      rst    = 1'b0;
      mon_on = 1'b1;
      expect_idle(16, "no_edge_after_reset");
      bus.set_req = 1'b0;
      expect_idle(12, "set_fall_ignored");

      // Single SET operation.
      d0 = done_cnt;
      bus.set_req = 1'b1;
      wait_busy("set_start", k);
      check_eq("set_latency", 32'(k), 32'd8);
      check_eq("set_setup", 32'({bus.S, bus.R, bus.EN}), 32'h4);
      tick(1);
      check_eq("set_pulse1", 32'({bus.S, bus.R, bus.EN}), 32'h5);
      tick(1);
      check_eq("set_pulse2", 32'({bus.S, bus.R, bus.EN}), 32'h5);
      tick(1);
      check_eq("set_hold", 32'({bus.S, bus.R, bus.EN}), 32'h4);
      tick(1);
      check_eq("set_check", 32'({bus.S, bus.R, bus.EN, bus.busy, bus.done}), 32'h02);
      tick(1);
      check_eq("set_done", 32'({bus.busy, bus.done, bus.err}), 32'h2);
      check_eq("set_q", 32'(bus.q_fb), 32'h1);
      bus.set_req = 1'b0;
      expect_idle(12, "after_set");
      check_eq("set_done_count", 32'(done_cnt - d0), 32'd1);

      // Glitches of 2 and 3 cycles are shorter than the debounce window.
      bus.clr_req = 1'b1;
      tick(2);
      bus.clr_req = 1'b0;
      expect_idle(16, "glitch2");
      bus.clr_req = 1'b1;
      tick(3);
      bus.clr_req = 1'b0;
      expect_idle(16, "glitch3");

      // Simultaneous requests: clear first, then set after one IDLE cycle.
      d0 = done_cnt;
      bus.set_req = 1'b1;
      bus.clr_req = 1'b1;
      wait_busy("both_start", k);
      check_eq("clr_first", 32'({bus.S, bus.R, bus.EN}), 32'h2);
      wait_done("clr_done");
      check_eq("clr_q", 32'(bus.q_fb), 32'h0);
      check_eq("gap_idle", 32'(bus.busy), 32'h0);
      tick(1);
      check_eq("set_second", 32'({bus.S, bus.R, bus.EN, bus.busy}), 32'h9);
      wait_done("set2_done");
      check_eq("set2_q", 32'(bus.q_fb), 32'h1);
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;
      expect_idle(12, "after_both");
      check_eq("both_done_count", 32'(done_cnt - d0), 32'd2);

      // Feedback stuck at Q=0: CHECK times out after 3 cycles.
      fb_force    = 1'b1;
      bus.set_req = 1'b1;
      wait_busy("to_start", k);
      tick(4);
      check_eq("to_check1", 32'({bus.busy, bus.done, bus.err}), 32'h4);
      tick(1);
      check_eq("to_check2", 32'({bus.busy, bus.done, bus.err}), 32'h4);
      tick(1);
      check_eq("to_check3", 32'({bus.busy, bus.done, bus.err}), 32'h4);
      tick(1);
      check_eq("to_done_err", 32'({bus.busy, bus.done, bus.err}), 32'h3);
      fb_force    = 1'b0;
      bus.set_req = 1'b0;
      expect_idle(12, "after_timeout");
      bus.clr_req = 1'b1;
      wait_busy("clr_after_to_start", k);
      wait_done("clr_after_to_done");
      check_eq("err_sticky", 32'(bus.err), 32'h1);
      check_eq("clr_after_to_q", 32'(bus.q_fb), 32'h0);
      bus.clr_req = 1'b0;
      expect_idle(12, "after_clr2");

      // Reset during PULSE of a clear with a set still pending.
      d0 = done_cnt;
      bus.set_req = 1'b1;
      bus.clr_req = 1'b1;
      wait_busy("mid_start", k);
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;
      tick(1);
      check_eq("mid_pulse", 32'({bus.S, bus.R, bus.EN}), 32'h3);
      mon_on = 1'b0;
      rst    = 1'b1;
      tick(1);
      check_eq("mid_rst", 32'({bus.S, bus.R, bus.EN, bus.busy, bus.done, bus.err}), 32'h0);
      rst = 1'b0;
      tick(1);
      mon_on = 1'b1;
      expect_idle(20, "mid_after");
      check_eq("mid_no_done", 32'(done_cnt - d0), 32'd0);

      // Normal operation resumes with err cleared.
      bus.set_req = 1'b1;
      wait_busy("resume_start", k);
      wait_done("resume_done");
      check_eq("resume_q", 32'(bus.q_fb), 32'h1);
      check_eq("resume_err", 32'(bus.err), 32'h0);
      bus.set_req = 1'b0;
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
